// File: rtl/ps2_pad_poller.sv
// ps2_pad_poller: periodically polls a PS2 pad over its 4-wire serial link and publishes the framed report
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   en                  polling enable; a frame already in flight always completes
//   spi_miso            pad DATA line
//   sclk, smosi, scs    pad CLOCK (idles high), COMMAND, ATTENTION (active low)
//   buttons             16 buttons, 1 = pressed
//   rx, ry, lx, ly      stick axes; 8'h80 unless a 9-byte frame from an analog (7x) pad
//   pad_id              id byte of the last good frame
//   analog_mode         id of the last good frame was 7x
//   frame_valid/err     one-clk strobes for each good / bad frame
module ps2_pad_poller #(
  parameter int CLK_DIV     = 150,
  parameter int GAP_HALVES  = 4,
  parameter int POLL_CYCLES = 500000,
  parameter int NUM_BYTES   = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        spi_miso,
  output logic        sclk,
  output logic        smosi,
  output logic        scs,
  output logic [15:0] buttons,
  output logic [7:0]  rx,
  output logic [7:0]  ry,
  output logic [7:0]  lx,
  output logic [7:0]  ly,
  output logic [7:0]  pad_id,
  output logic        analog_mode,
  output logic        frame_valid,
  output logic        frame_err
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = $clog2(POLL_CYCLES);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD, COMMIT} state_e;
  state_e state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [PW-1:0] poll_q, poll_d;
  logic pend_q, pend_d;
  logic [3:0] half_q, half_d, byte_q, byte_d;
  logic [7:0] rxs_q, rxs_d;
  logic [8:1][7:0] sh_q;
  logic sclk_q, smosi_q, scs_q;
  logic [15:0] buttons_q;
  logic [7:0] rx_q, ry_q, lx_q, ly_q, pad_id_q;
  logic analog_q, valid_q, err_q;
  logic tick, wrap, start, ok, analog_id, axes_ok;
  logic [7:0] tx_byte;
  assign tick      = div_q == DW'(CLK_DIV - 1);
  assign wrap      = poll_q == PW'(POLL_CYCLES - 1);
  // a wrap seen while busy is remembered in pend_q and honoured on the first IDLE cycle
  assign start     = state_q == IDLE && en && (wrap || pend_q);
  assign ok        = sh_q[2] == 8'h5A;
  assign analog_id = sh_q[1][7:4] == 4'h7;
  assign axes_ok   = NUM_BYTES == 9 && analog_id;
  // pad pins are registered from next-state so they never glitch
  assign tx_byte   = byte_d == 4'd0 ? 8'h01 : byte_d == 4'd1 ? 8'h42 : 8'h00;
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    byte_d  = byte_q;
    rxs_d   = rxs_q;
    poll_d  = wrap ? '0 : poll_q + 1'b1;
    pend_d  = en && (pend_q || wrap) && !start;
    div_d   = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
    case (state_q)
      IDLE:   if (start) state_d = SETUP;
      SETUP:  if (tick) begin
        state_d = SHIFT;
        half_d  = '0;
        byte_d  = '0;
      end
      SHIFT:  if (tick) begin
        half_d = half_q + 1'b1;
        // even halves are SCK low; the tick ending one is the SCK rising edge
        if (!half_q[0]) rxs_d = {spi_miso, rxs_q[7:1]};
        if (half_q == 4'd15) state_d = byte_q == 4'(NUM_BYTES - 1) ? HOLD : GAP;
      end
      GAP:    if (tick) begin
        half_d = half_q + 1'b1;
        if (half_q == 4'(GAP_HALVES - 1)) begin
          state_d = SHIFT;
          half_d  = '0;
          byte_d  = byte_q + 1'b1;
        end
      end
      HOLD:   if (tick) state_d = COMMIT;
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      poll_q    <= '0;
      pend_q    <= 1'b0;
      half_q    <= '0;
      byte_q    <= '0;
      rxs_q     <= '0;
      sclk_q    <= 1'b1;
      smosi_q   <= 1'b1;
      scs_q     <= 1'b1;
      buttons_q <= '0;
      rx_q      <= 8'h80;
      ry_q      <= 8'h80;
      lx_q      <= 8'h80;
      ly_q      <= 8'h80;
      pad_id_q  <= 8'hFF;
      analog_q  <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      poll_q  <= poll_d;
      pend_q  <= pend_d;
      half_q  <= half_d;
      byte_q  <= byte_d;
      rxs_q   <= rxs_d;
      sclk_q  <= state_d != SHIFT || half_d[0];
      smosi_q <= state_d != SHIFT || tx_byte[half_d[3:1]];
      scs_q   <= state_d == IDLE || state_d == COMMIT;
      valid_q <= state_q == COMMIT && ok;
      err_q   <= state_q == COMMIT && !ok;
      if (state_q == COMMIT && ok) begin
        buttons_q <= ~{sh_q[4], sh_q[3]};
        pad_id_q  <= sh_q[1];
        analog_q  <= analog_id;
        rx_q      <= axes_ok ? sh_q[5] : 8'h80;
        ry_q      <= axes_ok ? sh_q[6] : 8'h80;
        lx_q      <= axes_ok ? sh_q[7] : 8'h80;
        ly_q      <= axes_ok ? sh_q[8] : 8'h80;
      end
    end
  end
  // received bytes 1..N-1 are latched at the end of their 16th half-period
  always_ff @(posedge clk) begin
    if (state_q == SHIFT && tick && half_q == 4'd15 && byte_q != 4'd0) sh_q[byte_q] <= rxs_q;
  end
  assign sclk        = sclk_q;
  assign smosi       = smosi_q;
  assign scs         = scs_q;
  assign buttons     = buttons_q;
  assign rx          = rx_q;
  assign ry          = ry_q;
  assign lx          = lx_q;
  assign ly          = ly_q;
  assign pad_id      = pad_id_q;
  assign analog_mode = analog_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
endmodule

// File: tb/tb_ps2_pad_poller.sv
// tb_ps2_pad_poller: randomized pad-model bench for ps2_pad_poller
module tb_ps2_pad_poller;
  localparam int CD = 4;
  localparam int GH = 2;
  localparam int P  = 1024;
  localparam int NB = 9;
  localparam int FLEN = CD * (2 + 16 * NB + GH * (NB - 1)) + 1;
  localparam logic [56:0] RST_O = {16'h0000, 32'h80808080, 8'hFF, 1'b0};
  logic clk = 0, rst_n = 0, en = 1, spi_miso = 1;
  logic sclk, smosi, scs, analog_mode, frame_valid, frame_err;
  logic [15:0] buttons;
  logic [7:0] rx, ry, lx, ly, pad_id;
  wire [56:0] got_o = {buttons, rx, ry, lx, ly, pad_id, analog_mode};
  int total = 0, bad = 0;
  logic [7:0] resp [9];
  logic [56:0] exp_o;
  int cyc = 0, run = 0, bitn = 0, hexp, lo_bad = 0, hi_bad = 0, mosi_bad = 0, last_bits = 0, flen = 0;
  bit in_frame = 0, ps = 1, pk = 1, pmosi = 1;
  logic [71:0] cmdv = '0, last_cmd = '0;
  int starts [$];
  always #5 clk = ~clk;
  ps2_pad_poller #(.CLK_DIV(CD), .GAP_HALVES(GH), .POLL_CYCLES(P), .NUM_BYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .spi_miso(spi_miso), .sclk(sclk), .smosi(smosi), .scs(scs),
    .buttons(buttons), .rx(rx), .ry(ry), .lx(lx), .ly(ly), .pad_id(pad_id),
    .analog_mode(analog_mode), .frame_valid(frame_valid), .frame_err(frame_err));
  // pad model and link analyzer: answers resp[] LSB first, records MOSI and SCK phase lengths
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) in_frame = 0;
      if (ps && !scs) begin
        in_frame = 1; bitn = 0; cmdv = '0; starts.push_back(cyc);
      end else if (!ps && scs) begin
        if (in_frame) begin
          if (run != 2 * CD) hi_bad++;
          last_bits = bitn; last_cmd = cmdv;
        end
        in_frame = 0; spi_miso = 1'b1;
      end else if (in_frame && sclk != pk) begin
        if (!sclk) begin
          hexp = (bitn == 0) ? CD : (bitn % 8 == 0) ? (GH + 1) * CD : CD;
          if (run != hexp) hi_bad++;
          spi_miso = (bitn < 72) ? resp[bitn / 8][bitn % 8] : 1'b1;
        end else begin
          if (run != CD) lo_bad++;
          if (smosi !== pmosi) mosi_bad++;
          if (bitn < 72) cmdv[bitn] = smosi;
          bitn++;
        end
      end
      if ((frame_valid || frame_err) && starts.size() > 0) flen = cyc - starts[starts.size() - 1];
      run = (sclk != pk || scs != ps) ? 1 : run + 1;
      ps = scs; pk = sclk; pmosi = smosi;
    end
  end
  // reference: what a committed frame must publish, straight from the decoding rules
  function automatic logic [56:0] model(input logic [56:0] cur);
    logic an;
    if (resp[2] != 8'h5A) return cur;
    an = resp[1][7:4] == 4'h7;
    return {~{resp[4], resp[3]}, (NB == 9 && an) ? {resp[5], resp[6], resp[7], resp[8]} : 32'h80808080, resp[1], an};
  endfunction
  task automatic wait_frame(output bit v, output bit e);
    v = 0; e = 0;
    for (int i = 0; i < 3 * P && !v && !e; i++) begin
      @(negedge clk); #1;
      v = frame_valid; e = frame_err;
    end
  endtask
  task automatic rand_resp(input bit analog);
    for (int i = 0; i < 9; i++) resp[i] = 8'($urandom);
    resp[1] = analog ? 8'h73 : 8'h41;
    resp[2] = 8'h5A;
  endtask
  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (got_o !== RST_O) begin bad++; $display("FAIL reset_out got=%h want=%h", got_o, RST_O); end
    total++; if ({scs, sclk, smosi, frame_valid, frame_err} !== 5'b11100) begin bad++; $display("FAIL reset_pins got=%b want=11100", {scs, sclk, smosi, frame_valid, frame_err}); end
    rst_n = 1;
    exp_o = RST_O;
  endtask
  task automatic test_digital;
    bit v, e;
    rand_resp(0);
    resp[0] = 8'hFF; resp[3] = 8'hFF; resp[4] = 8'hFF;
    wait_frame(v, e);
    exp_o = model(exp_o);
    total++; if ({v, e} !== 2'b10) begin bad++; $display("FAIL digital_strobe got=%b want=10", {v, e}); end
    total++; if (got_o !== {16'h0000, 32'h80808080, 8'h41, 1'b0}) begin bad++; $display("FAIL digital_out got=%h want=%h", got_o, {16'h0000, 32'h80808080, 8'h41, 1'b0}); end
    @(negedge clk); #1;
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL valid_width got=%b want=0", frame_valid); end
  endtask
  task automatic test_analog;
    bit v, e;
    resp = '{8'hFF, 8'h73, 8'h5A, 8'hEF, 8'hBF, 8'h10, 8'h20, 8'h30, 8'h40};
    wait_frame(v, e);
    exp_o = model(exp_o);
    total++; if ({v, e} !== 2'b10) begin bad++; $display("FAIL analog_strobe got=%b want=10", {v, e}); end
    total++; if (got_o !== {16'h4010, 32'h10203040, 8'h73, 1'b1}) begin bad++; $display("FAIL analog_out got=%h want=%h", got_o, {16'h4010, 32'h10203040, 8'h73, 1'b1}); end
  endtask
  task automatic test_random;
    bit v, e;
    int sel;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 9; i++) resp[i] = 8'($urandom);
      sel = $urandom_range(0, 2);
      resp[1] = sel == 0 ? 8'h73 : sel == 1 ? 8'h41 : resp[1];
      if ($urandom_range(0, 3) != 0) resp[2] = 8'h5A;
      wait_frame(v, e);
      exp_o = model(exp_o);
      total++; if ({v, e} !== {resp[2] == 8'h5A, resp[2] != 8'h5A}) begin bad++; $display("FAIL rand%0d_strobe got=%b byte2=%h", k, {v, e}, resp[2]); end
      total++; if (got_o !== exp_o) begin bad++; $display("FAIL rand%0d_out got=%h want=%h", k, got_o, exp_o); end
    end
  endtask
  task automatic test_no_pad;
    bit v, e;
    for (int i = 0; i < 9; i++) resp[i] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      wait_frame(v, e);
      total++; if ({v, e} !== 2'b01) begin bad++; $display("FAIL nopad%0d_strobe got=%b want=01", k, {v, e}); end
      total++; if (got_o !== exp_o) begin bad++; $display("FAIL nopad%0d_held got=%h want=%h", k, got_o, exp_o); end
    end
  endtask
  task automatic test_timing(input int s0);
    total++; if (lo_bad !== 0) begin bad++; $display("FAIL sck_low got=%0d want=0", lo_bad); end
    total++; if (hi_bad !== 0) begin bad++; $display("FAIL sck_high got=%0d want=0", hi_bad); end
    total++; if (mosi_bad !== 0) begin bad++; $display("FAIL mosi_stable got=%0d want=0", mosi_bad); end
    total++; if (last_bits !== 8 * NB) begin bad++; $display("FAIL bit_count got=%0d want=%0d", last_bits, 8 * NB); end
    total++; if (last_cmd !== 72'h4201) begin bad++; $display("FAIL mosi_bytes got=%h want=%h", last_cmd, 72'h4201); end
    total++; if (flen !== FLEN) begin bad++; $display("FAIL frame_len got=%0d want=%0d", flen, FLEN); end
    total++; if (starts.size() - s0 < 8) begin bad++; $display("FAIL frame_count got=%0d want>=8", starts.size() - s0); end
    for (int i = s0 + 1; i < starts.size(); i++) begin
      total++; if (starts[i] - starts[i - 1] !== P) begin bad++; $display("FAIL poll_gap%0d got=%0d want=%0d", i, starts[i] - starts[i - 1], P); end
    end
  endtask
  task automatic test_mid_reset;
    bit v, e, hit;
    int t0, n;
    rand_resp(1);
    hit = 0;
    for (int i = 0; i < 2 * P && !hit; i++) begin
      @(negedge clk); #1;
      hit = in_frame && bitn >= 28;
    end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL mid_reset_reach got=%b want=1", hit); end
    rst_n = 0; t0 = cyc; n = starts.size();
    @(negedge clk); #1;
    rst_n = 1;
    exp_o = RST_O;
    total++; if ({scs, sclk, frame_valid, frame_err} !== 4'b1100) begin bad++; $display("FAIL mid_reset_pins got=%b want=1100", {scs, sclk, frame_valid, frame_err}); end
    total++; if (got_o !== RST_O) begin bad++; $display("FAIL mid_reset_out got=%h want=%h", got_o, RST_O); end
    for (int i = 0; i < 2 * P && starts.size() == n; i++) @(negedge clk);
    #1;
    total++; if (starts.size() <= n || starts[starts.size() - 1] - t0 !== P + 1) begin bad++; $display("FAIL mid_reset_restart got=%0d want=%0d", starts.size() > n ? starts[starts.size() - 1] - t0 : -1, P + 1); end
    wait_frame(v, e);
    exp_o = model(exp_o);
    total++; if ({v, e, got_o} !== {2'b10, exp_o}) begin bad++; $display("FAIL after_reset_frame got=%b/%h want=10/%h", {v, e}, got_o, exp_o); end
  endtask
  task automatic test_en_drop;
    bit v, e, hit;
    int n;
    rand_resp(1);
    hit = 0;
    for (int i = 0; i < 2 * P && !hit; i++) begin
      @(negedge clk); #1;
      hit = in_frame && bitn >= 18 && bitn < 24;
    end
    en = 0;
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL en_drop_reach got=%b want=1", hit); end
    wait_frame(v, e);
    exp_o = model(exp_o);
    total++; if ({v, e, got_o} !== {2'b10, exp_o}) begin bad++; $display("FAIL en_drop_commit got=%b/%h want=10/%h", {v, e}, got_o, exp_o); end
    n = starts.size();
    repeat (2 * P + 100) @(negedge clk);
    total++; if (starts.size() !== n) begin bad++; $display("FAIL en_off_starts got=%0d want=%0d", starts.size(), n); end
    en = 1;
    rand_resp(0);
    wait_frame(v, e);
    exp_o = model(exp_o);
    total++; if ({v, e, got_o} !== {2'b10, exp_o}) begin bad++; $display("FAIL en_back_frame got=%b/%h want=10/%h", {v, e}, got_o, exp_o); end
  endtask
  initial begin
    int s0;
    for (int i = 0; i < 9; i++) resp[i] = 8'hFF;
    test_reset;
    s0 = starts.size();
    test_digital;
    test_analog;
    test_random;
    test_no_pad;
    test_timing(s0);
    test_mid_reset;
    test_en_drop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
